cam_miss_handler: RTL and testbench
===================================

CAM_MISS_HANDLER -- requirements
Module: cam_miss_handler

Interface
REQ-001 Parameter AW, default 4, address width shared by client, associative memory and backing store.
REQ-002 Parameter DW, default 4, data width.
REQ-003 Parameter TIMEOUT, default 15, number of FETCH cycles without mem_ack before an error response (range 1..255).
REQ-004 clk  in  1  single clock; all flops update on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  client lookup request.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_addr  in  AW  lookup address.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  client accepts response.
REQ-011 rsp_data  out  DW  returned data.
REQ-012 rsp_hit  out  1  1 = served from associative memory, 0 = filled from backing store.
REQ-013 rsp_err  out  1  backing-store timeout.
REQ-014 am_wr / am_addr / am_din  out  1/AW/DW  drive associative memory wr, Address, Data_in.
REQ-015 am_dout / am_hit  in  DW/1  associative memory Data_out, Hit (registered, valid one cycle after read issue).
REQ-016 mem_req / mem_addr  out  1/AW  backing-store read request, level-held until ack.
REQ-017 mem_ack / mem_data  in  1/DW  backing-store single-cycle acknowledge with data.
REQ-018 miss_cnt  out  8  miss statistics (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, LOOKUP, CHECK, FETCH, FILL, RESP; one request in flight at a time.
REQ-020 IDLE: req_ready=1; on req_valid&&req_ready, register req_addr -> LOOKUP; request held nowhere else.
REQ-021 LOOKUP (1 cycle): am_wr=0, am_addr=latched address -> CHECK.
REQ-022 CHECK (1 cycle): sample am_hit; hit -> capture am_dout, rsp_hit=1 -> RESP; miss -> FETCH, timer cleared.
REQ-023 FETCH: mem_req=1, mem_addr=latched address; on mem_ack capture mem_data -> FILL; otherwise timer+1.
REQ-024 FETCH: timer reaching TIMEOUT without ack -> RESP with rsp_err=1, rsp_data=0, rsp_hit=0; no fill.
REQ-025 mem_ack in the same cycle as timeout expiry SHALL win (normal fill, no error).
REQ-026 FILL (exactly 1 cycle): am_wr=1, am_addr=latched address, am_din=fetched data -> RESP with rsp_hit=0; write is fire-and-forget, no readback.
REQ-027 RESP: rsp_valid=1, rsp_data/rsp_hit/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE.
REQ-028 Latency: hit = 3 cycles from accept to rsp_valid; miss = 4 + ack-wait cycles.
REQ-029 am_wr SHALL be 1 only in FILL; mem_req only in FETCH; mem_ack outside FETCH ignored.
REQ-030 am_addr/am_din/mem_addr SHALL hold last latched values outside their active states (no glitch toggling).

Reset
REQ-031 rst SHALL force IDLE immediately, independent of clk, aborting any operation including mid-FETCH (mem_req drops asynchronously).
REQ-032 Reset values: req_ready=1 after reset, rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_err=0, am_wr=0, am_addr=0, am_din=0, mem_req=0, mem_addr=0, miss_cnt=0, timer=0.

Configuration
REQ-033 Macro CAM_MISS_COUNT_EN defined: miss_cnt increments by 1 on each CHECK-miss, saturates at 255, cleared only by rst.
REQ-034 Macro undefined: miss_cnt tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-035 Hit: am model holds 0x5->0xA; request addr 0x5 -> rsp_valid on cycle 3, rsp_data=0xA, rsp_hit=1, mem_req never asserted.
REQ-036 Miss+fill: addr 0x3 absent, mem_ack after 2 cycles with 0x7 -> one-cycle am_wr=1, am_addr=0x3, am_din=0x7; rsp_data=0x7, rsp_hit=0; repeat addr 0x3 -> hit.
REQ-037 Timeout: TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, rsp_err=1, rsp_data=0, am_wr never 1; ack on 4th cycle -> normal fill, rsp_err=0.
REQ-038 Backpressure: rsp_ready low 5 cycles -> response fields stable, req_ready=0, new req_valid not accepted until handshake.
REQ-039 Reset mid-FETCH: assert rst between edges -> mem_req=0 at once, all outputs at reset values; next request completes normally.
REQ-040 With CAM_MISS_COUNT_EN: 300 misses -> miss_cnt=255; hits leave it unchanged; without macro miss_cnt=0 throughout.

Source files
------------

// File: rtl/cam_miss_handler_if.sv
// ---------------------------------------------------------------------------
// cam_miss_handler_if
//   Client-side request/response bundle of cam_miss_handler.
//
//   Handshake rules (both channels):
//     A transfer happens on a rising clk edge where valid && ready are both 1.
//     Once valid is raised, the sender holds valid and its payload stable
//     until that transfer. Ready may change freely and never waits on valid.
//
//   Signals
//     req_valid / req_ready / req_addr           lookup request channel
//     rsp_valid / rsp_ready / rsp_data /
//     rsp_hit / rsp_err                          response channel
//
//   Modports
//     master : the client (drives requests, consumes responses)
//     slave  : cam_miss_handler
// ---------------------------------------------------------------------------
interface cam_miss_handler_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_hit;
    logic          rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err
    );
endinterface

// File: rtl/cam_miss_handler.sv
// ---------------------------------------------------------------------------
// cam_miss_handler
//   Looks up one address at a time in an external associative memory. On a
//   miss it reads the backing store, writes the fetched word into the
//   associative memory and returns it; a backing store that stays silent for
//   TIMEOUT fetch cycles produces an error response instead.
//
//   Optional feature: define CAM_MISS_COUNT_EN to build an 8-bit saturating
//   miss counter on miss_cnt; without it miss_cnt is constant 0.
//
//   Ports
//     clk, rst          clock; asynchronous active-high reset
//     cl (slave)        client request/response bundle (cam_miss_handler_if)
//     am_wr/am_addr/am_din   associative memory write strobe, address, data
//     am_dout/am_hit    associative memory read data and hit flag
//                       (registered, valid the cycle after the read)
//     mem_req/mem_addr  backing-store read request, held until mem_ack
//     mem_ack/mem_data  backing-store one-cycle acknowledge with data
//     miss_cnt          miss statistics
//     dbg_state         current FSM state, for observation only
// ---------------------------------------------------------------------------
module cam_miss_handler #(
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    cam_miss_handler_if.slave   cl,
    output logic                am_wr,
    output logic [AW-1:0]       am_addr,
    output logic [DW-1:0]       am_din,
    input  logic [DW-1:0]       am_dout,
    input  logic                am_hit,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_data,
    output logic [7:0]          miss_cnt,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CHECK  = 3'd2,
        FETCH  = 3'd3,
        FILL   = 3'd4,
        RESP   = 3'd5
    } state_t;

    // The timer counts completed silent FETCH cycles; the last allowed one
    // is TIMEOUT-1, so mem_req stays high for exactly TIMEOUT cycles.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] timer;

    assign dbg_state = state;

    // am_addr doubles as the single copy of the accepted request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= 8'd0;
            cl.req_ready <= 1'b1;
            cl.rsp_valid <= 1'b0;
            cl.rsp_data  <= '0;
            cl.rsp_hit   <= 1'b0;
            cl.rsp_err   <= 1'b0;
            am_wr        <= 1'b0;
            am_addr      <= '0;
            am_din       <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cl.req_valid) begin
                        cl.req_ready <= 1'b0;
                        am_addr      <= cl.req_addr;
                        state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Read issued this cycle; result arrives in CHECK.
                    state <= CHECK;
                end
                CHECK: begin
                    if (am_hit) begin
                        cl.rsp_data  <= am_dout;
                        cl.rsp_hit   <= 1'b1;
                        cl.rsp_err   <= 1'b0;
                        cl.rsp_valid <= 1'b1;
                        state        <= RESP;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= am_addr;
                        timer    <= 8'd0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // An ack in the final allowed cycle still wins over timeout.
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        am_wr       <= 1'b1;
                        am_din      <= mem_data;
                        cl.rsp_data <= mem_data;
                        cl.rsp_hit  <= 1'b0;
                        cl.rsp_err  <= 1'b0;
                        state       <= FILL;
                    end else if (timer == TIMER_LAST) begin
                        mem_req      <= 1'b0;
                        cl.rsp_data  <= '0;
                        cl.rsp_hit   <= 1'b0;
                        cl.rsp_err   <= 1'b1;
                        cl.rsp_valid <= 1'b1;
                        state        <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                FILL: begin
                    am_wr        <= 1'b0;
                    cl.rsp_valid <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (cl.rsp_ready) begin
                        cl.rsp_valid <= 1'b0;
                        cl.req_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAM_MISS_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= 8'd0;
        end else if (state == CHECK && !am_hit && miss_cnt != 8'hFF) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end
`else
    assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cam_miss_handler.sv
// ---------------------------------------------------------------------------
// tb_cam_miss_handler
//   Bench for cam_miss_handler (TIMEOUT = 4). A small associative-memory
//   stub and a backing-store driver surround the DUT. Each transaction is
//   described by its address, the fetch cycle in which the backing store
//   acknowledges (or never), and the response backpressure; the expected
//   timeline of every output follows from those numbers.
// ---------------------------------------------------------------------------
module tb_cam_miss_handler;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cam_miss_handler_if #(.AW(AW), .DW(DW)) cl ();

    logic          am_wr;
    logic [AW-1:0] am_addr;
    logic [DW-1:0] am_din;
    logic [DW-1:0] am_dout;
    logic          am_hit;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic [7:0]    miss_cnt;
    logic [2:0]    dbg_state;

    cam_miss_handler #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cl(cl),
        .am_wr(am_wr), .am_addr(am_addr), .am_din(am_din),
        .am_dout(am_dout), .am_hit(am_hit),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock/reset bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- associative memory stub ----------------
    logic [DW-1:0] stub_d [16];
    logic          stub_v [16];
    logic          stub_init = 1'b1;
    logic          bd_en = 1'b0, bd_v = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (stub_init) begin
            for (int i = 0; i < 16; i++) stub_v[i] <= 1'b0;
        end else begin
            if (bd_en) begin
                stub_v[bd_addr] <= bd_v;
                stub_d[bd_addr] <= bd_data;
            end
            if (am_wr) begin
                stub_v[am_addr] <= 1'b1;
                stub_d[am_addr] <= am_din;
            end
        end
        am_hit  <= stub_v[am_addr];
        am_dout <= stub_d[am_addr];
    end

    // ---------------- reference model ----------------
    bit            ref_v [16];
    logic [DW-1:0] ref_d [16];
    int            base_miss = 0;

    bit            chk_en = 0;
    bit            cur_active = 0;
    int            cur_c0 = 0;
    logic [AW-1:0] cur_a = '0;
    bit            cur_hit = 0, cur_ack = 0, cur_err = 0;
    int            cur_d = 0, nf = 0, rsp_start = 0, rsp_end = 0;
    logic [DW-1:0] cur_data = '0;

    // observations of the last transaction, for the literal pins
    int            last_lat, last_mr, last_aw, last_rv;
    logic [DW-1:0] last_data, last_awd;
    logic [AW-1:0] last_awa;
    bit            last_hit, last_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tx    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_miss(input int m);
`ifdef CAM_MISS_COUNT_EN
        return (m > 255) ? 255 : m;
`else
        return 0 * m;
`endif
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        int rel;
        bit e_rv, e_mr, e_aw, e_rr;
        int e_mc;
        if (chk_en) begin
            rel  = 0;
            e_rv = 0; e_mr = 0; e_aw = 0; e_rr = 1;
            e_mc = base_miss;
            if (cur_active) begin
                rel  = cyc - cur_c0;
                e_rr = (rel == 0);
                e_rv = (rel >= rsp_start) && (rel <= rsp_end);
                e_mr = !cur_hit && rel >= 3 && rel < 3 + nf;
                e_aw = cur_ack && rel == 4 + cur_d;
                if (!cur_hit && rel >= 3) e_mc = base_miss + 1;
            end
            check("req_ready", cl.req_ready, e_rr);
            check("rsp_valid", cl.rsp_valid, e_rv);
            check("mem_req",   mem_req, e_mr);
            check("am_wr",     am_wr, e_aw);
            check("miss_cnt",  miss_cnt, sat_miss(e_mc));
            if (cur_active && rel >= 1) check("am_addr_hold", am_addr, cur_a);
            if (e_rv) begin
                check("rsp_data", cl.rsp_data, cur_data);
                check("rsp_hit",  cl.rsp_hit, !cur_hit ? 0 : 1);
                check("rsp_err",  cl.rsp_err, cur_err);
            end
            if (e_aw) check("am_din", am_din, cur_data);
            if (e_mr) check("mem_addr", mem_addr, cur_a);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, cl.req_ready, 1);
        check({tag, "_rsp_valid"}, cl.rsp_valid, 0);
        check({tag, "_rsp_data"},  cl.rsp_data, 0);
        check({tag, "_rsp_hit"},   cl.rsp_hit, 0);
        check({tag, "_rsp_err"},   cl.rsp_err, 0);
        check({tag, "_am_wr"},     am_wr, 0);
        check({tag, "_am_addr"},   am_addr, 0);
        check({tag, "_am_din"},    am_din, 0);
        check({tag, "_mem_req"},   mem_req, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_miss_cnt"},  miss_cnt, 0);
    endtask

    task automatic idle_cycle();
        cl.req_valid = 1'b0;
        cl.req_addr  = AW'($urandom);
        mem_ack      = ($urandom_range(0, 3) == 0);
        mem_data     = DW'($urandom);
        cl.rsp_ready = 1'($urandom_range(0, 1));
        next_cycle();
    endtask

    task automatic backdoor_set(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_en = 1'b1; bd_v = 1'b1; bd_addr = a; bd_data = d;
        ref_v[a] = 1'b1; ref_d[a] = d;
        cl.req_valid = 1'b0;
        mem_ack = 1'b0;
        next_cycle();
        bd_en = 1'b0;
    endtask

    // d < TO: backing store acks in fetch cycle d (0-based); d >= TO: never.
    // b: cycles rsp_ready stays low once the response is up.
    // abort_rel > 0: reset the DUT asynchronously in that cycle.
    task automatic run_tx(input logic [AW-1:0] a, input bit flush, input int d,
                          input logic [DW-1:0] fd, input int b, input int abort_rel);
        bit in_fetch;
        if (flush) ref_v[a] = 1'b0;
        cur_a   = a;
        cur_hit = ref_v[a];
        cur_ack = !cur_hit && d < TO;
        cur_d   = d;
        if (cur_hit) begin
            cur_data = ref_d[a]; cur_err = 0; nf = 0; rsp_start = 3;
        end else if (cur_ack) begin
            cur_data = fd; cur_err = 0; nf = d + 1; rsp_start = 5 + d;
        end else begin
            cur_data = '0; cur_err = 1; nf = TO; rsp_start = 3 + TO;
        end
        rsp_end    = rsp_start + b;
        cur_c0     = cyc;
        cur_active = 1;
        last_lat = -1; last_mr = 0; last_aw = 0; last_rv = 0;
        last_awa = '0; last_awd = '0; last_data = '0; last_hit = 0; last_err = 0;
        for (int rel = 0; rel <= rsp_end; rel++) begin
            if (rel > 0) next_cycle();
            if (cl.rsp_valid) begin
                last_rv++;
                if (last_lat < 0) begin
                    last_lat  = rel;
                    last_data = cl.rsp_data;
                    last_hit  = cl.rsp_hit;
                    last_err  = cl.rsp_err;
                end
            end
            if (mem_req) last_mr++;
            if (am_wr) begin
                last_aw++;
                last_awa = am_addr;
                last_awd = am_din;
            end
            bd_en = (rel == 0) && flush;
            bd_v = 1'b0; bd_addr = a;
            cl.req_valid = 1'b1;
            cl.req_addr  = (rel == 0) ? a : AW'($urandom);
            in_fetch = !cur_hit && rel >= 3 && rel < 3 + nf;
            if (cur_ack && rel == 3 + d) begin
                mem_ack = 1'b1; mem_data = fd;
            end else if (!in_fetch) begin
                mem_ack = ($urandom_range(0, 2) == 0); mem_data = DW'($urandom);
            end else begin
                mem_ack = 1'b0; mem_data = DW'($urandom);
            end
            cl.rsp_ready = (rel < rsp_start) ? 1'($urandom_range(0, 1)) : (rel == rsp_end);
            if (abort_rel > 0 && rel == abort_rel) begin
                chk_en = 0;
                #2 rst = 1'b1;
                #1;
                check_reset_values("midfetch");
                @(negedge clk);
                #1 rst = 1'b0;
                cur_active = 0;
                base_miss  = 0;
                cl.req_valid = 1'b0;
                mem_ack = 1'b0;
                next_cycle();
                chk_en = 1;
                return;
            end
        end
        next_cycle();
        if (!cur_hit) base_miss++;
        if (cur_ack) begin
            ref_v[a] = 1'b1;
            ref_d[a] = fd;
        end
        cur_active = 0;
        n_tx++;
        cl.req_valid = 1'b0;
        mem_ack = 1'b0;
        cl.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cl.req_valid = 1'b0;
        cl.req_addr  = '0;
        cl.rsp_ready = 1'b0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 1'b0;
            ref_d[i] = '0;
        end

        #1 rst = 1'b1;
        #2;
        check_reset_values("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stub_init = 1'b0;
        next_cycle();
        chk_en = 1;

        // hit on a preloaded entry
        backdoor_set(4'h5, 4'hA);
        run_tx(4'h5, 0, 0, 4'h0, 0, 0);
        check("hit_latency", last_lat, 3);
        check("hit_data", last_data, 4'hA);
        check("hit_flag", last_hit, 1);
        check("hit_no_mem_req", last_mr, 0);

        // miss, ack in second fetch cycle, then the same address hits
        run_tx(4'h3, 1, 1, 4'h7, 0, 0);
        check("miss_latency", last_lat, 6);
        check("miss_am_wr_cycles", last_aw, 1);
        check("miss_am_addr", last_awa, 4'h3);
        check("miss_am_din", last_awd, 4'h7);
        check("miss_data", last_data, 4'h7);
        check("miss_hit_flag", last_hit, 0);
        run_tx(4'h3, 0, 0, 4'h0, 1, 0);
        check("refill_hit_flag", last_hit, 1);
        check("refill_hit_data", last_data, 4'h7);

        // timeout, then ack in the last allowed fetch cycle
        run_tx(4'h6, 1, TO, 4'h0, 0, 0);
        check("to_latency", last_lat, 7);
        check("to_mem_req_cycles", last_mr, 4);
        check("to_no_am_wr", last_aw, 0);
        check("to_err", last_err, 1);
        check("to_data", last_data, 0);
        run_tx(4'h6, 1, TO - 1, 4'hC, 2, 0);
        check("lastack_err", last_err, 0);
        check("lastack_mem_req_cycles", last_mr, 4);
        check("lastack_am_wr_cycles", last_aw, 1);
        check("lastack_data", last_data, 4'hC);

        // backpressure
        run_tx(4'h5, 0, 0, 4'h0, 5, 0);
        check("bp_rsp_valid_cycles", last_rv, 6);

        // reset mid-fetch, then a clean transaction
        run_tx(4'h9, 1, TO, 4'h0, 0, 4);
        idle_cycle();
        run_tx(4'h9, 1, 0, 4'h2, 0, 0);
        check("post_reset_latency", last_lat, 5);
        check("post_reset_data", last_data, 4'h2);
`ifdef CAM_MISS_COUNT_EN
        check("post_reset_miss_cnt", miss_cnt, 1);
`else
        check("post_reset_miss_cnt", miss_cnt, 0);
`endif

        // randomized traffic until the miss counter has saturated
        while ((base_miss < 300 || n_tx < 350) && n_tx < 3000) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            run_tx(AW'($urandom), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, TO + 1), DW'($urandom),
                   $urandom_range(0, 3), 0);
        end
        check("reached_300_misses", (base_miss >= 300), 1);
        for (int i = 0; i < 20; i++) begin
            run_tx(AW'($urandom), 0, $urandom_range(0, TO - 1), DW'($urandom),
                   $urandom_range(0, 2), 0);
        end
        idle_cycle();
`ifdef CAM_MISS_COUNT_EN
        check("final_miss_cnt", miss_cnt, 255);
`else
        check("final_miss_cnt", miss_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
